grid_io_tile_cfgchain: RTL and testbench

//  Parametrised IO tile: N_GPIO bidirectional pads, N_GPIN input-only pads and N_GPOUT output-only pads.
//  Per-GPIO configuration is loaded serially through the ccff chain, which has a bit counter and done/overflow status.

---
 rtl/grid_io_tile_cfgchain.sv | 108 ++++++++++
 tb/tb_grid_io_tile_cfgchain.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_io_tile_cfgchain.sv
// rtl/grid_io_tile_cfgchain.sv - perimeter IO tile with serial config chain, done/overflow status
// Optional per-channel odd parity check enabled by defining GRID_IO_CFG_PARITY_EN.
module grid_io_tile_cfgchain #(
   parameter int N_GPIO  = 8,
   parameter int N_GPIN  = 8,
   parameter int N_GPOUT = 8,
   parameter int CFG_W   = 2
) (
   input  logic                prog_clk,
   input  logic                pReset_n,
   input  logic                ccff_en,
   input  logic                ccff_head,
   output logic                ccff_tail,
   inout  wire  [N_GPIO-1:0]   gfpga_pad_GPIO_PAD,
   inout  wire  [N_GPIN-1:0]   gfpga_pad_GPIN_PAD,
   inout  wire  [N_GPOUT-1:0]  gfpga_pad_GPOUT_PAD,
   input  logic [N_GPIO-1:0]   io_outpad,
   output logic [N_GPIO-1:0]   io_inpad,
   input  logic [N_GPOUT-1:0]  gp_outpad,
   output logic [N_GPIN-1:0]   gp_inpad,
   output logic                cfg_done,
   output logic                cfg_overflow
`ifdef GRID_IO_CFG_PARITY_EN
   ,output logic [N_GPIO-1:0]  cfg_parity_err
`endif
);

`ifdef GRID_IO_CFG_PARITY_EN
   localparam int CH_W = CFG_W + 1;
`else
   localparam int CH_W = CFG_W;
`endif
   localparam int TOTAL = N_GPIO * CH_W;
   localparam int CNT_W = $clog2(TOTAL + 1);

   logic [TOTAL-1:0]  chain;
   logic [TOTAL-1:0]  chain_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              full;
   logic              last_shift;
   logic [N_GPIO-1:0] oe_eff;
   logic [N_GPIO-1:0] ie_eff;

   assign chain_nxt  = {chain[TOTAL-2:0], ccff_head};
   assign full       = (cnt == CNT_W'(TOTAL));
   assign last_shift = ccff_en && (cnt == CNT_W'(TOTAL - 1));
   assign ccff_tail  = chain[TOTAL-1];

   // Once full, further shifts still pass data through but permanently kill cfg_done.
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         chain        <= '0;
         cnt          <= '0;
         cfg_done     <= 1'b0;
         cfg_overflow <= 1'b0;
      end else if (ccff_en) begin
         chain <= chain_nxt;
         if (full) begin
            cfg_overflow <= 1'b1;
            cfg_done     <= 1'b0;
         end else begin
            cnt <= cnt + 1'b1;
            if (last_shift)
               cfg_done <= 1'b1;
         end
      end
   end

`ifdef GRID_IO_CFG_PARITY_EN
   // Parity is judged once, on the bits landing with the final shift.
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         cfg_parity_err <= '0;
      end else if (ccff_en && full) begin
         cfg_parity_err <= '0;
      end else if (last_shift) begin
         for (int i = 0; i < N_GPIO; i++)
            cfg_parity_err[i] <= ~(^chain_nxt[i*CH_W +: CH_W]);
      end
   end
`endif

   always_comb begin
      oe_eff = '0;
      ie_eff = '0;
      for (int i = 0; i < N_GPIO; i++) begin
`ifdef GRID_IO_CFG_PARITY_EN
         oe_eff[i] = chain[i*CH_W]     & ~cfg_parity_err[i];
         ie_eff[i] = chain[i*CH_W + 1] & ~cfg_parity_err[i];
`else
         oe_eff[i] = chain[i*CH_W];
         ie_eff[i] = chain[i*CH_W + 1];
`endif
      end
   end

   genvar g;
   generate
      for (g = 0; g < N_GPIO; g++) begin : g_gpio
         assign gfpga_pad_GPIO_PAD[g] = (cfg_done && oe_eff[g]) ? io_outpad[g] : 1'bz;
      end
   endgenerate

   assign gfpga_pad_GPOUT_PAD = cfg_done ? gp_outpad : {N_GPOUT{1'bz}};
   assign io_inpad            = {N_GPIO{cfg_done}} & ie_eff & gfpga_pad_GPIO_PAD;
   assign gp_inpad            = {N_GPIN{cfg_done}} & gfpga_pad_GPIN_PAD;

endmodule

// File: tb/tb_grid_io_tile_cfgchain.sv
// tb/tb_grid_io_tile_cfgchain.sv - self-checking bench for grid_io_tile_cfgchain
// Pads carry pullups so an undriven (Z) pad reads as 1.
module tb_grid_io_tile_cfgchain;
   localparam int N = 8;
`ifdef GRID_IO_CFG_PARITY_EN
   localparam int CH_W = 3;
`else
   localparam int CH_W = 2;
`endif
   localparam int TOTAL = N * CH_W;

   logic prog_clk = 1'b0;
   logic pReset_n = 1'b0;
   logic ccff_en = 1'b0;
   logic ccff_head = 1'b0;
   logic [7:0] io_outpad = 8'h00;
   logic [7:0] gp_outpad = 8'h33;
   logic [7:0] gpin_val = 8'h5A;
   logic [7:0] tb_gpio_en = 8'h00;
   logic [7:0] tb_gpio_val = 8'h00;
   wire [7:0] gpio_pad, gpin_pad, gpout_pad;
   wire [7:0] io_inpad, gp_inpad;
   wire ccff_tail, cfg_done, cfg_overflow;
`ifdef GRID_IO_CFG_PARITY_EN
   wire [7:0] cfg_parity_err;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_pads
         pullup(gpio_pad[gi]);
         pullup(gpout_pad[gi]);
         assign gpio_pad[gi] = tb_gpio_en[gi] ? tb_gpio_val[gi] : 1'bz;
      end
   endgenerate
   assign gpin_pad = gpin_val;

   grid_io_tile_cfgchain #(.N_GPIO(8), .N_GPIN(8), .N_GPOUT(8), .CFG_W(2)) dut (
      .prog_clk(prog_clk), .pReset_n(pReset_n), .ccff_en(ccff_en), .ccff_head(ccff_head),
      .ccff_tail(ccff_tail), .gfpga_pad_GPIO_PAD(gpio_pad), .gfpga_pad_GPIN_PAD(gpin_pad),
      .gfpga_pad_GPOUT_PAD(gpout_pad), .io_outpad(io_outpad), .io_inpad(io_inpad),
      .gp_outpad(gp_outpad), .gp_inpad(gp_inpad), .cfg_done(cfg_done), .cfg_overflow(cfg_overflow)
`ifdef GRID_IO_CFG_PARITY_EN
      , .cfg_parity_err(cfg_parity_err)
`endif
   );

   always #5 prog_clk = ~prog_clk;

   // Model: history of accepted bits, newest first; chain position p holds the bit shifted p shifts ago.
   bit hq[$];
   int nsh = 0;
   int n_chk = 0;
   int n_pass = 0;
   bit run = 1'b0;
   logic stream[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   function automatic bit cbit(input int p);
      return (p < hq.size()) ? hq[p] : 1'b0;
   endfunction

   function automatic bit m_done();
      return nsh == TOTAL;
   endfunction

   function automatic logic [7:0] m_perr();
      logic [7:0] r;
      r = '0;
`ifdef GRID_IO_CFG_PARITY_EN
      for (int i = 0; i < N; i++) begin
         bit x;
         x = 1'b0;
         for (int b = 0; b < CH_W; b++) x ^= cbit(i*CH_W + b);
         r[i] = m_done() && !x;
      end
`endif
      return r;
   endfunction

   function automatic logic [7:0] m_gpio();
      logic [7:0] r, pe;
      pe = m_perr();
      for (int i = 0; i < N; i++)
         r[i] = (m_done() && cbit(i*CH_W) && !pe[i]) ? io_outpad[i]
              : (tb_gpio_en[i] ? tb_gpio_val[i] : 1'b1);
      return r;
   endfunction

   function automatic logic [7:0] m_inpad();
      logic [7:0] r, pe, g;
      pe = m_perr();
      g = m_gpio();
      for (int i = 0; i < N; i++)
         r[i] = m_done() && cbit(i*CH_W + 1) && !pe[i] && g[i];
      return r;
   endfunction

   always @(negedge prog_clk) begin
      if (run) begin
         chk("tail", {31'd0, ccff_tail}, {31'd0, cbit(TOTAL-1)});
         chk("done", {31'd0, cfg_done}, {31'd0, m_done()});
         chk("overflow", {31'd0, cfg_overflow}, {31'd0, nsh > TOTAL});
         chk("gpio_pad", {24'd0, gpio_pad}, {24'd0, m_gpio()});
         chk("io_inpad", {24'd0, io_inpad}, {24'd0, m_inpad()});
         chk("gpout_pad", {24'd0, gpout_pad}, {24'd0, m_done() ? gp_outpad : 8'hFF});
         chk("gp_inpad", {24'd0, gp_inpad}, {24'd0, m_done() ? gpin_val : 8'h00});
`ifdef GRID_IO_CFG_PARITY_EN
         chk("parity_err", {24'd0, cfg_parity_err}, {24'd0, m_perr()});
`endif
      end
   end

   task automatic shift1(input bit en, input bit d);
      ccff_en = en;
      ccff_head = d;
      @(posedge prog_clk);
      if (en && pReset_n) begin
         hq.push_front(d);
         if (hq.size() > TOTAL) void'(hq.pop_back());
         nsh++;
      end
      #1;
      ccff_en = 1'b0;
   endtask

   // First bit shifted ends at ccff_tail, so channels go out top channel, top bit first.
   task automatic build(input logic [7:0] oe, input logic [7:0] ie, input logic [7:0] bad);
      logic [CH_W-1:0] c;
      stream.delete();
      for (int i = N - 1; i >= 0; i--) begin
         c = '0;
         c[0] = oe[i];
         c[1] = ie[i];
`ifdef GRID_IO_CFG_PARITY_EN
         c[2] = ~(oe[i] ^ ie[i]) ^ bad[i];
`endif
         for (int b = CH_W - 1; b >= 0; b--) stream.push_back(c[b]);
      end
   endtask

   task automatic do_reset();
      @(posedge prog_clk);
      #2;
      pReset_n = 1'b0;
      hq.delete();
      nsh = 0;
      #1;
      chk("rst_done", {31'd0, cfg_done}, 32'd0);
      chk("rst_ovf", {31'd0, cfg_overflow}, 32'd0);
      chk("rst_tail", {31'd0, ccff_tail}, 32'd0);
      chk("rst_inpad", {24'd0, io_inpad}, 32'd0);
      chk("rst_gp_inpad", {24'd0, gp_inpad}, 32'd0);
      chk("rst_gpio_z", {24'd0, gpio_pad}, 32'hFF);
      @(posedge prog_clk);
      #1;
      pReset_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic first_bit;
      int idx;
      run = 1'b1;
      @(posedge prog_clk);
      #1;
      chk("init_gpio_z", {24'd0, gpio_pad}, 32'hFF);
      chk("init_gpout_z", {24'd0, gpout_pad}, 32'hFF);
      pReset_n = 1'b1;

      // Drive-only load, then overflow
      io_outpad = 8'hA5;
      build(8'hFF, 8'h00, 8'h00);
      for (int k = 0; k < TOTAL - 1; k++) shift1(1'b1, stream[k]);
      chk("t1_done_early", {31'd0, cfg_done}, 32'd0);
      chk("t1_gpio_z", {24'd0, gpio_pad}, 32'hFF);
      shift1(1'b1, stream[TOTAL-1]);
      chk("t1_done", {31'd0, cfg_done}, 32'd1);
      chk("t1_gpio", {24'd0, gpio_pad}, 32'hA5);
      chk("t1_inpad", {24'd0, io_inpad}, 32'h00);
      chk("t1_gpout", {24'd0, gpout_pad}, 32'h33);
      chk("t1_gp_inpad", {24'd0, gp_inpad}, 32'h5A);
      shift1(1'b1, 1'b0);
      chk("t3_ovf", {31'd0, cfg_overflow}, 32'd1);
      chk("t3_done", {31'd0, cfg_done}, 32'd0);
      chk("t3_gpio_z", {24'd0, gpio_pad}, 32'hFF);
      for (int k = 0; k < 3; k++) shift1(k[0], 1'b1);
      chk("t3_ovf_hold", {31'd0, cfg_overflow}, 32'd1);
      chk("t3_done_hold", {31'd0, cfg_done}, 32'd0);

      // Input-only load with externally driven pads
      do_reset();
      io_outpad = 8'hFF;
      tb_gpio_val = 8'h3C;
      tb_gpio_en = 8'hFF;
      build(8'h00, 8'hFF, 8'h00);
      for (int k = 0; k < TOTAL - 1; k++) shift1(1'b1, stream[k]);
      chk("t2_inpad_early", {24'd0, io_inpad}, 32'h00);
      shift1(1'b1, stream[TOTAL-1]);
      chk("t2_inpad", {24'd0, io_inpad}, 32'h3C);
      tb_gpio_val = 8'hC3;
      shift1(1'b0, 1'b0);
      chk("t2_inpad2", {24'd0, io_inpad}, 32'hC3);
      tb_gpio_en = 8'h00;

      // Load with random ccff_en gaps and mixed channel modes
      do_reset();
      io_outpad = 8'h5F;
      build(8'h96, 8'h6B, 8'h00);
      first_bit = stream[0];
      idx = 0;
      while (idx < TOTAL) begin
         if ($urandom_range(0, 1) == 1) begin
            shift1(1'b1, stream[idx]);
            idx++;
         end else begin
            shift1(1'b0, 1'($urandom_range(0, 1)));
         end
         if (idx < TOTAL) chk("t4_not_done", {31'd0, cfg_done}, 32'd0);
      end
      chk("t4_done", {31'd0, cfg_done}, 32'd1);
      chk("t4_tail", {31'd0, ccff_tail}, {31'd0, first_bit});
      chk("t4_gpio", {24'd0, gpio_pad}, 32'h7F);
      chk("t4_inpad", {24'd0, io_inpad}, 32'h6B);
      for (int k = 0; k < 4; k++) shift1(1'b0, 1'b1);
      chk("t4_hold", {31'd0, cfg_done}, 32'd1);

      // Reset in the middle of a load, then loopback load
      do_reset();
      build(8'hFF, 8'hFF, 8'h00);
      for (int k = 0; k < 9; k++) shift1(1'b1, stream[k]);
      do_reset();
      io_outpad = 8'h3C;
      for (int k = 0; k < TOTAL - 1; k++) shift1(1'b1, stream[k]);
      chk("t5_done_early", {31'd0, cfg_done}, 32'd0);
      shift1(1'b1, stream[TOTAL-1]);
      chk("t5_done", {31'd0, cfg_done}, 32'd1);
      chk("t5_gpio", {24'd0, gpio_pad}, 32'h3C);
      chk("t5_loopback", {24'd0, io_inpad}, 32'h3C);

`ifdef GRID_IO_CFG_PARITY_EN
      // Channel 3 carries even parity
      do_reset();
      io_outpad = 8'h00;
      build(8'hFF, 8'h00, 8'h08);
      for (int k = 0; k < TOTAL; k++) shift1(1'b1, stream[k]);
      chk("t6_perr", {24'd0, cfg_parity_err}, 32'h08);
      chk("t6_gpio", {24'd0, gpio_pad}, 32'h08);
      shift1(1'b1, 1'b0);
      chk("t6_perr_clr", {24'd0, cfg_parity_err}, 32'h00);
`endif

      shift1(1'b0, 1'b0);
      run = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
